// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - next-PC select codes, NOP encoding, IF/ID occupancy type
package fetch_stage_pkg;

  localparam logic [1:0]  PCSRC_JALR   = 2'b00;
  localparam logic [1:0]  PCSRC_TARGET = 2'b01;
  localparam logic [1:0]  PCSRC_SEQ    = 2'b10;
  localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

  typedef enum logic {
    IFID_BUBBLE = 1'b0,
    IFID_VALID  = 1'b1
  } ifid_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - IF/ID pipeline register, priority reset > flush > stall > advance
module fetch_stage_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_pc_plus4,
  input  logic [31:0]     fetch_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid
);

  ifid_state_t state_q;
  ifid_state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IFID_BUBBLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)       state_d = IFID_BUBBLE;
    else if (!stall) state_d = IFID_VALID;
  end

  always_comb begin
    ifid_valid = (state_q == IFID_VALID);
  end

  // A flush only swaps in the bubble; the pc fields keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      ifid_instr    <= NOP_INSTR;
    end else if (flush) begin
      ifid_instr    <= NOP_INSTR;
    end else if (!stall) begin
      ifid_pc       <= fetch_pc;
      ifid_pc_plus4 <= fetch_pc_plus4;
      ifid_instr    <= fetch_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage: PC register, next-PC mux, IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int            XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]   NOP_INSTR = NOP_ENCODING
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            stall,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_stall_cycles
`endif
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            redirect;

  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);

  // Reserved code 11 falls into the sequential default.
  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    case (pc_src)
      PCSRC_JALR: begin
        next_pc  = jalr_target & ~XLEN'(1);
        redirect = 1'b1;
      end
      PCSRC_TARGET: begin
        next_pc  = branch_target;
        redirect = 1'b1;
      end
      PCSRC_SEQ: next_pc = pc_plus4;
      default:   next_pc = pc_plus4;
    endcase
  end

  // Redirect outranks stall: the redirecting instruction is older.
  always_ff @(posedge clk) begin
    if (rst)                    pc <= RESET_PC;
    else if (redirect || !stall) pc <= next_pc;
  end

  fetch_stage_ifid_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk            (clk),
    .rst            (rst),
    .flush          (redirect),
    .stall          (stall),
    .fetch_pc       (pc),
    .fetch_pc_plus4 (pc_plus4),
    .fetch_instr    (imem_rdata),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_instr     (ifid_instr),
    .ifid_valid     (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (redirect)           perf_redirects    <= sat_inc32(perf_redirects);
      if (stall && !redirect) perf_stall_cycles <= sat_inc32(perf_stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage (FETCH_PERF_CNT_EN enables counter checks)
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_src = 2'b10;
  logic [31:0] branch_target = '0;
  logic [31:0] jalr_target = '0;
  logic        stall = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  assign imem_rdata = 32'hAAAA_0000 | imem_addr;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .stall         (stall),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Drive one cycle, advance the reference model, push its prediction, compare after the edge.
  task automatic step(input logic r, input logic [1:0] src, input logic [31:0] bt,
                      input logic [31:0] jt, input logic st);
    exp_t e;
    exp_t got;
    logic [31:0] tgt;
    logic redir;
    @(negedge clk);
    rst = r; pc_src = src; branch_target = bt; jalr_target = jt; stall = st;
    redir = (src == 2'b00) || (src == 2'b01);
    tgt   = (src == 2'b00) ? {jt[31:1], 1'b0} : bt;
    if (r) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP; m_valid = 1'b0;
    end else if (redir) begin
      m_pc = tgt; m_instr = NOP; m_valid = 1'b0;
    end else if (!st) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = 32'hAAAA_0000 | m_pc;
      m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    e.addr = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4; e.instr = m_instr; e.valid = m_valid;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("sb_imem_addr", imem_addr, got.addr);
    check("sb_ifid_pc", ifid_pc, got.ipc);
    check("sb_ifid_pc_plus4", ifid_pc_plus4, got.ipc4);
    check("sb_ifid_instr", ifid_instr, got.instr);
    check("sb_ifid_valid", {31'b0, ifid_valid}, {31'b0, got.valid});
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] held_pc, held_instr;
    m_pc = '0; m_ipc = '0; m_ipc4 = '0; m_instr = NOP; m_valid = 1'b0;

    // Reset for two cycles, then sequential fetch
    step(1'b1, 2'b10, 32'h0, 32'h0, 1'b0);
    step(1'b1, 2'b10, 32'h0, 32'h0, 1'b0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instr, NOP);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    seq(1);
    check("seq1_addr", imem_addr, 32'h4);
    check("seq1_instr", ifid_instr, 32'hAAAA_0000);
    check("seq1_valid", {31'b0, ifid_valid}, 32'h1);
    seq(2);
    check("seq3_addr", imem_addr, 32'hC);
    check("seq3_pc_plus4", ifid_pc_plus4, 32'hC);
    seq(1);
    check("seq4_addr", imem_addr, 32'h10);

    // Branch redirect at pc=0x10
    step(1'b0, 2'b01, 32'h40, 32'h0, 1'b0);
    check("br_addr", imem_addr, 32'h40);
    check("br_valid", {31'b0, ifid_valid}, 32'h0);
    check("br_instr", ifid_instr, NOP);
    seq(1);
    check("br_ifid_pc", ifid_pc, 32'h40);
    check("br_ifid_valid", {31'b0, ifid_valid}, 32'h1);

    // JALR target with bit0 set
    step(1'b0, 2'b00, 32'h0, 32'h0000_0105, 1'b0);
    check("jalr_addr", imem_addr, 32'h104);
    check("jalr_valid", {31'b0, ifid_valid}, 32'h0);

    // Stall for 3 cycles at pc=0x20, then redirect over stall
    step(1'b0, 2'b01, 32'h1C, 32'h0, 1'b0);
    seq(1);
    held_pc = ifid_pc; held_instr = ifid_instr;
    for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 32'h0, 32'h0, 1'b1);
    check("stall_addr", imem_addr, 32'h20);
    check("stall_ifid_pc", ifid_pc, held_pc);
    check("stall_ifid_instr", ifid_instr, held_instr);
    step(1'b0, 2'b01, 32'h80, 32'h0, 1'b1);
    check("redir_over_stall_addr", imem_addr, 32'h80);
    check("redir_over_stall_valid", {31'b0, ifid_valid}, 32'h0);

    // Wrap with reserved code 11
    step(1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0);
    step(1'b0, 2'b11, 32'h0, 32'h0, 1'b0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc_plus4", ifid_pc_plus4, 32'h0);
    check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);

    // Back-to-back redirects keep the slot empty
    step(1'b0, 2'b01, 32'h200, 32'h0, 1'b0);
    step(1'b0, 2'b00, 32'h0, 32'h301, 1'b0);
    check("b2b_valid", {31'b0, ifid_valid}, 32'h0);
    check("b2b_addr", imem_addr, 32'h300);

    // Reset with stall and redirect asserted
    seq(2);
    step(1'b1, 2'b01, 32'h80, 32'h0, 1'b1);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_valid", {31'b0, ifid_valid}, 32'h0);
    seq(1);
    check("midrst_first_fetch", ifid_pc, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    step(1'b1, 2'b10, 32'h0, 32'h0, 1'b0);
    check("perf_rst_redir", perf_redirects, 32'h0);
    check("perf_rst_stall", perf_stall_cycles, 32'h0);
    step(1'b0, 2'b10, 32'h0, 32'h0, 1'b1);
    step(1'b0, 2'b10, 32'h0, 32'h0, 1'b1);
    step(1'b0, 2'b01, 32'h40, 32'h0, 1'b1);
    step(1'b0, 2'b00, 32'h0, 32'h80, 1'b0);
    seq(1);
    check("perf_redirects", perf_redirects, 32'd2);
    check("perf_stall_cycles", perf_stall_cycles, 32'd2);
    step(1'b1, 2'b10, 32'h0, 32'h0, 1'b1);
    check("perf_clr_redir", perf_redirects, 32'h0);
    check("perf_clr_stall", perf_stall_cycles, 32'h0);
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
           $urandom, $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
